// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding beside decode: picks the youngest ready in-flight
// result per source operand, raises load-use stalls, and keeps stall statistics plus a watchdog.
module hazard_fwd_unit #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RSEL_W    = 3,
  parameter int unsigned NSTAGE    = 3,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       src_valid,
  input  logic [RSEL_W-1:0]          src_a_sel,
  input  logic [RSEL_W-1:0]          src_b_sel,
  input  logic                       src_a_use,
  input  logic                       src_b_use,
  input  logic [DATA_W-1:0]          src_a_rf,
  input  logic [DATA_W-1:0]          src_b_rf,
  input  logic [NSTAGE-1:0]          stg_wr,
  input  logic [NSTAGE*RSEL_W-1:0]   stg_wsel,
  input  logic [NSTAGE-1:0]          stg_rdy,
  input  logic [NSTAGE*DATA_W-1:0]   stg_data,
  input  logic                       fwd_off,
  input  logic                       flush,
  output logic [DATA_W-1:0]          src_a_out,
  output logic [DATA_W-1:0]          src_b_out,
  output logic [NSTAGE-1:0]          fwd_a_hit,
  output logic [NSTAGE-1:0]          fwd_b_hit,
  output logic                       stall,
  output logic [15:0]                stall_total,
  output logic                       hazard_err
);

  localparam int unsigned RUN_W = $clog2(MAX_STALL);
  localparam logic [RUN_W-1:0] RunMax = RUN_W'(MAX_STALL - 1);

  logic             hz_a, hz_b;
  logic [RUN_W-1:0] stall_run_q;

  function automatic void resolve(
    input  logic                     en,
    input  logic [RSEL_W-1:0]        sel,
    input  logic [DATA_W-1:0]        rf,
    input  logic [NSTAGE-1:0]        wr,
    input  logic [NSTAGE*RSEL_W-1:0] wsel,
    input  logic [NSTAGE-1:0]        rdy,
    input  logic [NSTAGE*DATA_W-1:0] data,
    input  logic                     off,
    output logic [DATA_W-1:0]        res,
    output logic [NSTAGE-1:0]        hit,
    output logic                     hz
  );
    logic [NSTAGE-1:0] match;
    logic [NSTAGE-1:0] young;
    logic [DATA_W-1:0] ydata;
    for (int i = 0; i < NSTAGE; i++) begin
      match[i] = en & wr[i] & (wsel[i*RSEL_W +: RSEL_W] == sel);
    end
    // Isolate the lowest set bit: the youngest stage writing this register.
    young = match & ~(match - NSTAGE'(1));
    ydata = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      ydata = ydata | ({DATA_W{young[i]}} & data[i*DATA_W +: DATA_W]);
    end
    res = rf;
    hit = '0;
    hz  = 1'b0;
    if (young != '0) begin
      // With forwarding off only the writeback stage may supply data (write-then-read).
      if ((off && !young[NSTAGE-1]) || ((young & rdy) == '0)) begin
        hz = 1'b1;
      end else begin
        res = ydata;
        hit = young;
      end
    end
  endfunction

  always_comb begin
    resolve(src_a_use, src_a_sel, src_a_rf, stg_wr, stg_wsel, stg_rdy, stg_data, fwd_off,
            src_a_out, fwd_a_hit, hz_a);
    resolve(src_b_use, src_b_sel, src_b_rf, stg_wr, stg_wsel, stg_rdy, stg_data, fwd_off,
            src_b_out, fwd_b_hit, hz_b);
  end

  assign stall = rst & src_valid & ~flush & (hz_a | hz_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_run_q <= '0;
      stall_total <= '0;
      hazard_err  <= 1'b0;
    end else if (stall) begin
      if (stall_run_q == RunMax) begin
        hazard_err <= 1'b1;
      end else begin
        stall_run_q <= stall_run_q + 1'b1;
      end
      if (stall_total != 16'hFFFF) begin
        stall_total <= stall_total + 16'd1;
      end
    end else begin
      stall_run_q <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed and randomized bench for hazard_fwd_unit against a behavioural reference model.
module tb_hazard_fwd_unit;

  localparam int unsigned DW  = 16;
  localparam int unsigned RW  = 3;
  localparam int unsigned NS  = 3;
  localparam int unsigned MXS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            src_valid;
  logic [RW-1:0]   src_a_sel, src_b_sel;
  logic            src_a_use, src_b_use;
  logic [DW-1:0]   src_a_rf, src_b_rf;
  logic [NS-1:0]   stg_wr;
  logic [NS*RW-1:0] stg_wsel;
  logic [NS-1:0]   stg_rdy;
  logic [NS*DW-1:0] stg_data;
  logic            fwd_off, flush;
  logic [DW-1:0]   src_a_out, src_b_out;
  logic [NS-1:0]   fwd_a_hit, fwd_b_hit;
  logic            stall;
  logic [15:0]     stall_total;
  logic            hazard_err;

  int checks = 0;
  int errors = 0;
  int m_run = 0;
  int m_total = 0;
  bit m_err = 0;

  hazard_fwd_unit #(
    .DATA_W(DW), .RSEL_W(RW), .NSTAGE(NS), .MAX_STALL(MXS)
  ) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid),
    .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
    .src_a_use(src_a_use), .src_b_use(src_b_use),
    .src_a_rf(src_a_rf), .src_b_rf(src_b_rf),
    .stg_wr(stg_wr), .stg_wsel(stg_wsel), .stg_rdy(stg_rdy), .stg_data(stg_data),
    .fwd_off(fwd_off), .flush(flush),
    .src_a_out(src_a_out), .src_b_out(src_b_out),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .stall(stall), .stall_total(stall_total), .hazard_err(hazard_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan stages from youngest to oldest, stop at the first writer of the register.
  function automatic void ref_res(input logic en, input logic [RW-1:0] sel,
                                  input logic [DW-1:0] rf, output logic [DW-1:0] d,
                                  output logic [NS-1:0] h, output logic hz);
    int y = -1;
    for (int i = 0; i < NS; i++) begin
      if (y < 0 && en && stg_wr[i] && stg_wsel[i*RW +: RW] == sel) y = i;
    end
    d = rf; h = '0; hz = 1'b0;
    if (y >= 0) begin
      if ((fwd_off && y < NS - 1) || !stg_rdy[y]) hz = 1'b1;
      else begin
        d = stg_data[y*DW +: DW];
        h = NS'(1 << y);
      end
    end
  endfunction

  function automatic bit ref_stall();
    logic [DW-1:0] d; logic [NS-1:0] h; logic za, zb;
    ref_res(src_a_use, src_a_sel, src_a_rf, d, h, za);
    ref_res(src_b_use, src_b_sel, src_b_rf, d, h, zb);
    return rst && src_valid && !flush && (za || zb);
  endfunction

  task automatic check_all(input string tag);
    logic [DW-1:0] da, db; logic [NS-1:0] ha, hb; logic za, zb;
    ref_res(src_a_use, src_a_sel, src_a_rf, da, ha, za);
    ref_res(src_b_use, src_b_sel, src_b_rf, db, hb, zb);
    check({tag, ".stall"}, 32'(stall), 32'(ref_stall()));
    if (!za) begin
      check({tag, ".a_out"}, 32'(src_a_out), 32'(da));
      check({tag, ".a_hit"}, 32'(fwd_a_hit), 32'(ha));
    end
    if (!zb) begin
      check({tag, ".b_out"}, 32'(src_b_out), 32'(db));
      check({tag, ".b_hit"}, 32'(fwd_b_hit), 32'(hb));
    end
    check({tag, ".total"}, 32'(stall_total), 32'(m_total));
    check({tag, ".err"}, 32'(hazard_err), 32'(m_err));
  endtask

  // One clock edge; the model's counters advance from the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (ref_stall()) begin
        if (m_run >= MXS - 1) m_err = 1'b1;
        m_run++;
        if (m_total < 65535) m_total++;
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    src_valid = 1'b0; src_a_sel = '0; src_b_sel = '0; src_a_use = 1'b0; src_b_use = 1'b0;
    src_a_rf = 16'h0A0A; src_b_rf = 16'h0B0B; stg_wr = '0; stg_wsel = '0; stg_rdy = '0;
    stg_data = '0; fwd_off = 1'b0; flush = 1'b0;
  endtask

  task automatic set_stage(input int i, input logic w, input logic [RW-1:0] s,
                           input logic r, input logic [DW-1:0] d);
    stg_wr[i] = w; stg_wsel[i*RW +: RW] = s; stg_rdy[i] = r; stg_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    m_run = 0; m_total = 0; m_err = 1'b0;
    #12;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #2;
    do_reset();

    // Reset state and basic forward from execute.
    #1;
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.total", 32'(stall_total), 32'd0);
    check("rst.err", 32'(hazard_err), 32'd0);
    src_valid = 1'b1; src_a_use = 1'b1; src_a_sel = 3'd3;
    set_stage(0, 1'b1, 3'd3, 1'b1, 16'h1234);
    #1;
    check("t1.a_out", 32'(src_a_out), 32'h1234);
    check("t1.a_hit", 32'(fwd_a_hit), 32'b001);
    check("t1.stall", 32'(stall), 32'd0);
    tick();

    // Youngest writer wins.
    src_b_use = 1'b1; src_b_sel = 3'd5;
    set_stage(0, 1'b1, 3'd5, 1'b1, 16'hAAAA);
    set_stage(2, 1'b1, 3'd5, 1'b1, 16'h5555);
    #1;
    check("t2.b_out", 32'(src_b_out), 32'hAAAA);
    check("t2.b_hit", 32'(fwd_b_hit), 32'b001);
    check("t2.a_out", 32'(src_a_out), 32'h0A0A);
    check("t2.a_hit", 32'(fwd_a_hit), 32'b000);
    tick();

    // Load-use: one stall, then forward from memory stage.
    clear_inputs();
    src_valid = 1'b1; src_a_use = 1'b1; src_a_sel = 3'd2;
    set_stage(0, 1'b1, 3'd2, 1'b0, 16'hDEAD);
    #1;
    check("t3.stall", 32'(stall), 32'd1);
    tick();
    set_stage(0, 1'b0, 3'd0, 1'b1, 16'h0000);
    set_stage(1, 1'b1, 3'd2, 1'b1, 16'h00FF);
    #1;
    check("t3.stall2", 32'(stall), 32'd0);
    check("t3.a_out", 32'(src_a_out), 32'h00FF);
    check("t3.a_hit", 32'(fwd_a_hit), 32'b010);
    check("t3.total", 32'(stall_total), 32'd1);
    tick();

    // Forwarding disabled: memory-stage match stalls, writeback-only match forwards.
    clear_inputs();
    src_valid = 1'b1; src_a_use = 1'b1; src_a_sel = 3'd4; fwd_off = 1'b1;
    set_stage(1, 1'b1, 3'd4, 1'b1, 16'h1111);
    #1;
    check("t4.stall", 32'(stall), 32'd1);
    set_stage(1, 1'b0, 3'd0, 1'b0, 16'h0000);
    set_stage(2, 1'b1, 3'd4, 1'b1, 16'hBEEF);
    #1;
    check("t4.a_out", 32'(src_a_out), 32'hBEEF);
    check("t4.a_hit", 32'(fwd_a_hit), 32'b100);
    check("t4.stall2", 32'(stall), 32'd0);
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      src_valid = ($urandom_range(0, 9) != 0);
      src_a_sel = RW'($urandom_range(0, 3));
      src_b_sel = RW'($urandom_range(0, 3));
      src_a_use = ($urandom_range(0, 4) != 0);
      src_b_use = ($urandom_range(0, 4) != 0);
      src_a_rf  = DW'($urandom);
      src_b_rf  = DW'($urandom);
      for (int i = 0; i < NS; i++) begin
        set_stage(i, $urandom_range(0, 1) == 1, RW'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, DW'($urandom));
      end
      fwd_off = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      #1;
      check_all($sformatf("rnd%0d", n));
      tick();
    end

    // Flush clears the run; eight consecutive stalls trip the watchdog.
    do_reset();
    src_valid = 1'b1; src_a_use = 1'b1; src_a_sel = 3'd1;
    set_stage(0, 1'b1, 3'd1, 1'b0, 16'h0001);
    repeat (7) tick();
    flush = 1'b1;
    #1;
    check("t5.flush_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    repeat (7) tick();
    check("t5.err_pre", 32'(hazard_err), 32'd0);
    check("t5.total", 32'(stall_total), 32'd14);
    tick();
    check("t5.err_set", 32'(hazard_err), 32'd1);
    set_stage(0, 1'b0, 3'd0, 1'b1, 16'h0000);
    repeat (3) tick();
    check("t5.err_sticky", 32'(hazard_err), 32'd1);
    check_all("t5.model");

    // Saturation of the stall total, then asynchronous reset mid-stall.
    do_reset();
    src_valid = 1'b1; src_a_use = 1'b1; src_a_sel = 3'd6;
    set_stage(0, 1'b1, 3'd6, 1'b0, 16'h0006);
    repeat (65534) tick();
    check("t6.total_pre", 32'(stall_total), 32'hFFFE);
    repeat (3) tick();
    check("t6.total_sat", 32'(stall_total), 32'hFFFF);
    check_all("t6.model");
    #2;
    rst = 1'b0;
    #1;
    check("t6.rst_total", 32'(stall_total), 32'd0);
    check("t6.rst_err", 32'(hazard_err), 32'd0);
    check("t6.rst_stall", 32'(stall), 32'd0);
    m_run = 0; m_total = 0; m_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6.post_stall", 32'(stall), 32'd1);
    tick();
    check("t6.post_total", 32'(stall_total), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard-detection and operand-forwarding unit for the pipelined core, sitting beside decode. Compares decode source-register selects against every downstream stage's pending write and selects the youngest ready result or the register-file value. Adds load-use stall generation, a no-forwarding mode, a stall watchdog and stall statistics, none of which the existing fixed three-stage forwarding vector provides.

Parameters:
DATA_W, 16, datapath width in bits
RSEL_W, 3, register-select width; register count is 2**RSEL_W
NSTAGE, 3, number of downstream write-back stages tracked (index 0 = youngest/execute, NSTAGE-1 = writeback)
MAX_STALL, 8, consecutive-stall watchdog limit (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
src_valid  in  1  decode holds a valid instruction
src_a_sel  in  RSEL_W  source A register
src_b_sel  in  RSEL_W  source B register
src_a_use  in  1  instruction reads source A
src_b_use  in  1  instruction reads source B
src_a_rf  in  DATA_W  register-file read A
src_b_rf  in  DATA_W  register-file read B
stg_wr  in  NSTAGE  stage i holds an instruction that writes a register
stg_wsel  in  NSTAGE*RSEL_W  destination of stage i, slice [i*RSEL_W +: RSEL_W]
stg_rdy  in  NSTAGE  result of stage i is available this cycle (0 for load in execute)
stg_data  in  NSTAGE*DATA_W  result of stage i, slice [i*DATA_W +: DATA_W]
fwd_off  in  1  1 = forwarding disabled mode
flush  in  1  branch/jump flush of decode
src_a_out  out  DATA_W  resolved operand A
src_b_out  out  DATA_W  resolved operand B
fwd_a_hit  out  NSTAGE  one-hot stage used for A (0 = register file)
fwd_b_hit  out  NSTAGE  one-hot stage used for B
stall  out  1  hold fetch/decode, insert bubble into execute
stall_total  out  16  saturating count of stall cycles
hazard_err  out  1  sticky watchdog error

Behaviour:
- Match for operand X at stage i: src_X_use & stg_wr[i] & (stg_wsel_i == src_X_sel). All registers are general (no hard-wired zero).
- Youngest match wins (lowest i). Older matches are ignored when a younger one exists.
- Forwarding mode (fwd_off=0): youngest match ready -> src_X_out = stg_data_i, fwd_X_hit = 1<<i; youngest match not ready -> operand hazard; no match -> src_X_rf, hit = 0.
- No-forward mode (fwd_off=1): any match at i < NSTAGE-1 -> operand hazard; match only at NSTAGE-1 with stg_rdy -> forward from that stage (write-then-read equivalent).
- stall = src_valid & ~flush & (hazard_A | hazard_B), combinational, same-cycle. While stall=1, src_X_out/fwd_X_hit still show the resolution logic's value but consumers must ignore them.
- flush has priority over stall: flush=1 forces stall=0 and clears the run counter.
- Internal stall_run counter: increments on each stall cycle, clears on any non-stall cycle or flush. If stall_run reaches MAX_STALL-1 while stall=1, hazard_err sets on that edge and stays 1 until reset.
- stall_total increments on every stall cycle and saturates at 0xFFFF (no wrap).
- Reset (rst=0, asynchronous): stall_run=0, stall_total=0, hazard_err=0; stall forced 0 while in reset. Combinational data outputs follow the inputs.
- Reset asserted mid-stall: all counters clear immediately, with no partial count retained.
- Simultaneous A and B hazards count as one stall cycle.

Test Plan:
1. Reset -> stall=0, stall_total=0, hazard_err=0. Then src_a_sel=3, stg_wr=001, stg_wsel0=3, stg_rdy=001, stg_data0=0x1234 -> src_a_out=0x1234, fwd_a_hit=001, stall=0.
2. Priority: stages 0 and 2 both write r5 (0xAAAA, 0x5555), all ready, src_b_sel=5 -> src_b_out=0xAAAA, fwd_b_hit=001.
3. Load-use: stage 0 writes r2 with stg_rdy[0]=0, src_a_sel=2 -> stall=1 for 1 cycle. Next cycle stage 1 writes r2 ready with 0x00FF -> stall=0, src_a_out=0x00FF, stall_total=1.
4. fwd_off=1: stage 1 writes r4, src_a_sel=4 -> stall=1. Match only at stage 2 (ready, 0xBEEF) -> src_a_out=0xBEEF, stall=0.
5. flush=1 during hazard -> stall=0, run counter cleared. Hold a hazard 8 cycles with MAX_STALL=8 -> hazard_err rises after the 8th stall edge and stays high until rst low.
6. Saturation: force stall 65537 cycles (or preload via bench backdoor) -> stall_total holds 0xFFFF. Assert rst mid-stall -> all counters 0 asynchronously.
